// File: rtl/pr_dma_chunker.sv
// Splits one PR DMA read request into host-DMA descriptors that never cross a
// 2^CHUNK_BITS boundary, with a bounded outstanding count and one done pulse per request.
module pr_dma_chunker #(
  parameter int PADDR_BITS      = 40,
  parameter int LEN_BITS        = 28,
  parameter int CHUNK_BITS      = 12,
  parameter int MAX_OUTSTANDING = 8,
  localparam int OUT_BITS       = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic                  s_req_valid,
  output logic                  s_req_ready,
  input  logic [PADDR_BITS-1:0] s_req_paddr,
  input  logic [LEN_BITS-1:0]   s_req_len,
  input  logic                  s_req_last,
  output logic                  s_rsp_done,
  output logic                  m_req_valid,
  input  logic                  m_req_ready,
  output logic [PADDR_BITS-1:0] m_req_paddr,
  output logic [LEN_BITS-1:0]   m_req_len,
  output logic                  m_req_last,
  input  logic                  m_cpl_valid,
  output logic                  busy,
  output logic [OUT_BITS-1:0]   outstanding,
  output logic [31:0]           chunk_cnt,
  output logic                  cpl_err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_e;

  localparam logic [LEN_BITS-1:0] CHUNK_SZ = LEN_BITS'(1) << CHUNK_BITS;
  localparam logic [OUT_BITS-1:0] MAX_OUT  = OUT_BITS'(MAX_OUTSTANDING);

  state_e                state_q, state_d;
  logic [PADDR_BITS-1:0] addr_q, addr_d;
  logic [LEN_BITS-1:0]   rem_q, rem_d;
  logic                  lst_q, lst_d;
  logic                  done_q, done_d;
  logic [OUT_BITS-1:0]   out_q, out_d;
  logic [31:0]           cnt_q, cnt_d;
  logic                  err_q, err_d;

  logic [LEN_BITS-1:0]   room;
  logic [LEN_BITS-1:0]   clen;
  logic                  is_final;
  logic                  hs;

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      lst_q   <= 1'b0;
      done_q  <= 1'b0;
      out_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      lst_q   <= lst_d;
      done_q  <= done_d;
      out_q   <= out_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // valid depends only on registered state, and outstanding can only fall while a
  // descriptor is pending, so valid and payload hold until the handshake.
  always_comb begin
    room     = CHUNK_SZ - LEN_BITS'(addr_q[CHUNK_BITS-1:0]);
    clen     = (rem_q < room) ? rem_q : room;
    is_final = (clen == rem_q);
    hs       = (state_q == ISSUE) && (out_q < MAX_OUT) && m_req_ready;

    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    lst_d   = lst_q;
    done_d  = 1'b0;
    out_d   = out_q;
    cnt_d   = cnt_q + 32'(hs);
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        if (s_req_valid) begin
          addr_d = s_req_paddr;
          rem_d  = s_req_len;
          lst_d  = s_req_last;
          if (s_req_len == '0) done_d  = 1'b1;
          else                 state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (hs) begin
          addr_d = addr_q + PADDR_BITS'(clen);
          rem_d  = rem_q - clen;
          if (is_final) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (out_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    case ({hs, m_cpl_valid})
      2'b10:   out_d = out_q + 1'b1;
      2'b01: begin
        if (out_q == '0) err_d = 1'b1;
        else             out_d = out_q - 1'b1;
      end
      default: out_d = out_q;
    endcase
  end

  assign s_req_ready = (state_q == IDLE);
  assign s_rsp_done  = done_q | ((state_q == DRAIN) && (out_q == '0));
  assign m_req_valid = (state_q == ISSUE) && (out_q < MAX_OUT);
  assign m_req_paddr = addr_q;
  assign m_req_len   = clen;
  assign m_req_last  = lst_q & is_final;
  assign busy        = (state_q != IDLE);
  assign outstanding = out_q;
  assign chunk_cnt   = cnt_q;
  assign cpl_err     = err_q;

endmodule
